// File: rtl/rr_arb5_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb5_pkg
// Shared definitions for the 5-way round-robin arbiter controller:
//   NREQ     - number of requesters
//   PTR_W    - width of requester indices (pointer / owner)
//   HOLD_W   - width of the ownership hold counter (covers MAX_HOLD up to 255)
//   state_t  - arbiter state encoding
//   next_idx - modulo-NREQ increment of a requester index
// -----------------------------------------------------------------------------
package rr_arb5_pkg;

    localparam int NREQ   = 5;
    localparam int PTR_W  = 3;
    localparam int HOLD_W = 8;

    typedef logic [PTR_W-1:0]  idx_t;
    typedef logic [HOLD_W-1:0] hold_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Step a requester index upward, wrapping from the last requester to 0.
    function automatic idx_t next_idx(input idx_t i);
        return (i == idx_t'(NREQ - 1)) ? idx_t'(0) : idx_t'(i + idx_t'(1));
    endfunction

endpackage

// File: rtl/onehot5_check.sv
// -----------------------------------------------------------------------------
// onehot5_check
// Purely combinational "exactly one bit set" detector for a 5-bit vector.
// Ports:
//   vec     in  [4:0]  vector under test
//   one_hot out        1 when exactly one bit of vec is set
// -----------------------------------------------------------------------------
module onehot5_check
    import rr_arb5_pkg::*;
(
    input  logic [NREQ-1:0] vec,
    output logic            one_hot
);

    // Clearing the lowest set bit leaves zero only for single-bit vectors.
    always_comb begin
        one_hot = (vec != '0) && ((vec & (vec - NREQ'(1))) == '0);
    end

endmodule

// File: rtl/rr_arb5_ctrl.sv
// -----------------------------------------------------------------------------
// rr_arb5_ctrl
// Five-requester round-robin arbiter with bounded ownership.
// A requester keeps the grant while it holds its request, up to MAX_HOLD
// consecutive cycles; it is then forcibly released with a timeout pulse.
// Every release is followed by one idle cycle, and the search pointer moves
// to the requester after the previous owner so it drops to lowest priority.
// Ports:
//   clk     in        rising-edge clock
//   rst_n   in        asynchronous active-low reset
//   req     in  [4:0] request per requester, held while in use
//   grant   out [4:0] registered one-hot grant, zero when idle
//   owner   out [2:0] registered index of the granted requester, 0 when idle
//   busy    out       registered OR of grant
//   timeout out       registered one-cycle pulse on forced release
//   err     out       registered sticky flag: grant seen non-zero, not one-hot
// -----------------------------------------------------------------------------
module rr_arb5_ctrl
    import rr_arb5_pkg::*;
#(
    parameter int MAX_HOLD = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] owner,
    output logic             busy,
    output logic             timeout,
    output logic             err
);

    localparam hold_t HOLD_LAST = hold_t'(MAX_HOLD - 1);

    state_t state;
    idx_t   ptr;
    hold_t  hold_cnt;

    idx_t   win_idx;
    logic   win_found;
    logic   grant_one_hot;

    // Round-robin winner: first set request scanning upward from ptr.
    always_comb begin
        idx_t cand;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment would infer latches.
        win_idx   = '0;
        win_found = 1'b0;
        cand      = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
            cand = next_idx(cand);
        end
    end

    onehot5_check u_onehot (
        .vec     (grant),
        .one_hot (grant_one_hot)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            err      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if ((grant != '0) && !grant_one_hot) begin
                err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state    <= ST_BUSY;
                        grant    <= NREQ'(1) << win_idx;
                        owner    <= win_idx;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end

                ST_BUSY: begin
                    if (!req[owner] || (hold_cnt == HOLD_LAST)) begin
                        // Release: the owner goes to the back of the queue.
                        state    <= ST_IDLE;
                        grant    <= '0;
                        owner    <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        ptr      <= next_idx(owner);
                        timeout  <= req[owner];
                    end else begin
                        hold_cnt <= hold_cnt + hold_t'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rr_arb5_ctrl.md
RR_ARB5_CTRL -- requirements
Module: rr_arb5_ctrl

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles per ownership (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  5  request per requester x[4:0]; held high for the duration of use.
REQ-005 grant  output  5  registered one-hot grant; all-zero when idle.
REQ-006 owner  output  3  registered binary index of granted requester; 0 when idle.
REQ-007 busy  output  1  registered; equals OR of grant.
REQ-008 timeout  output  1  registered single-cycle pulse on forced release.
REQ-009 err  output  1  registered sticky flag: grant observed non-zero and not exactly one-hot.

Function
REQ-010 The block SHALL implement two states: IDLE (grant=0) and BUSY (exactly one grant bit set).
REQ-011 IDLE -> BUSY: when req != 0 at a rising edge, grant SHALL be set at that edge (latency 1 cycle from req sampled).
REQ-012 Winner SHALL be the first set req bit scanning upward from ptr, wrapping 4->0.
REQ-013 ptr SHALL be a 3-bit register, range 0..4; on every release ptr SHALL become (owner+1) mod 5.
REQ-014 BUSY: grant SHALL hold unchanged while req[owner]=1 and hold_cnt < MAX_HOLD-1; hold_cnt SHALL start at 0 on grant and increment each BUSY cycle.
REQ-015 Release: when req[owner]=0 at an edge, the block SHALL return to IDLE, grant=0, at that edge.
REQ-016 Forced release: when hold_cnt = MAX_HOLD-1 with req[owner] still 1, the block SHALL return to IDLE and pulse timeout for exactly one cycle.
REQ-017 After any release, the block SHALL spend exactly one cycle in IDLE before granting again, even if req != 0 at the release edge.
REQ-018 A requester forcibly released and still requesting SHALL have lowest priority at the next arbitration (via REQ-013).
REQ-019 Requests from non-owners during BUSY SHALL be ignored (no preemption); changes to req in BUSY other than req[owner] SHALL have no effect.
REQ-020 err SHALL be set on the edge following a cycle where grant != 0 and grant is not one-hot; it SHALL remain 1 until reset.
REQ-021 owner SHALL always equal the index of the set grant bit; busy SHALL equal |grant.

Reset
REQ-022 rst_n low SHALL asynchronously force grant=0, owner=0, busy=0, timeout=0, err=0, ptr=0, hold_cnt=0, state IDLE, including mid-ownership.
REQ-023 First arbitration after reset deassertion SHALL occur at the first rising edge with rst_n high and req != 0.

Structure
REQ-024 State encodings, NREQ=5, and pointer width SHALL live in a shared package/include rr_arb5_pkg.
REQ-025 The one-hot check SHALL be a separate combinational sub-module onehot5_check (5-bit in, 1-bit "exactly one set" out), instantiated on grant to drive err.
REQ-026 Round-robin winner selection SHALL be combinational from req and ptr; all outputs SHALL be registers.

Verification
REQ-027 Reset, req=5'b00100 held -> grant=5'b00100, owner=2 one edge later; drop req -> grant=0 next edge; ptr=3.
REQ-028 ptr=3, req=5'b11111 pulsed per grant -> grant order 3,4,0,1,2, each separated by one idle cycle.
REQ-029 MAX_HOLD=4, req=5'b00001 held, req[3]=1 -> grant[0] for 4 cycles, timeout pulse, one idle cycle, then grant=5'b01000.
REQ-030 req=5'b00000 throughout -> grant=0, busy=0, timeout=0, err=0 for 100 cycles.
REQ-031 Owner 4 releases, req=5'b10001 at release edge -> one idle cycle, then grant=5'b00001 (wrap 4->0).
REQ-032 rst_n low mid-grant -> all outputs 0 immediately without clock; after release req=5'b00010 -> grant=5'b00010.
